// File: rtl/ram_boot_loader.sv
// ---------------------------------------------------------------------------------------------
// ram_boot_loader
//
// Copies a boot image from an SPI NOR flash into the instruction/data SRAM (port 0) before the
// CPU core is released from reset. A single continuous flash read is issued:
//   opcode (8 bits) -> 24-bit address -> [8 dummy SCK cycles] -> BOOT_WORDS x 32 data bits.
// Each received word is written to RAM in the cycle after its last bit is sampled. Once the
// final word is written the loader parks in DONE, raises done_o/core_rst_no and hands RAM
// port 0 over to the SoC combinationally.
//
// Optional feature macro:
//   BOOT_LOADER_FAST_READ_EN  - use FAST_READ (8'h0B) with an 8-cycle dummy phase.
//                              Undefined: plain READ (8'h03), no dummy phase.
//
// Parameters:
//   RAM_ADDR_WIDTH - RAM word-address width
//   BOOT_WORDS     - number of 32-bit words copied (1 .. 2**RAM_ADDR_WIDTH)
//   FLASH_OFFSET   - flash byte address of the first image byte
//   CLK_DIV        - SCK half-period in clk_i cycles (>= 1)
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   sck_o, sdo_o, sdi_i    - SPI mode 0 serial clock / data out / data in
//   cs_o                   - SPI chip select, active low
//   soc_*_i                - SoC request to RAM port 0 (only honoured in DONE)
//   ram_*_o                - RAM port 0 request (loader writes, or SoC pass-through in DONE)
//   core_rst_no            - active-low CPU core reset, released in DONE
//   done_o                 - image loaded
// ---------------------------------------------------------------------------------------------
module ram_boot_loader #(
   parameter int unsigned RAM_ADDR_WIDTH = 11,
   parameter int unsigned BOOT_WORDS     = 2048,
   parameter logic [23:0] FLASH_OFFSET   = 24'h100000,
   parameter int unsigned CLK_DIV        = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   // SPI flash
   output logic                      sck_o,
   output logic                      sdo_o,
   input  logic                      sdi_i,
   output logic                      cs_o,
   // SoC side
   input  logic                      soc_en_i,
   input  logic                      soc_we_i,
   input  logic [3:0]                soc_be_i,
   input  logic [RAM_ADDR_WIDTH-1:0] soc_addr_i,
   input  logic [31:0]               soc_wdata_i,
   // RAM port 0
   output logic                      ram_en_o,
   output logic                      ram_we_o,
   output logic [3:0]                ram_be_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]               ram_wdata_o,
   // Status
   output logic                      core_rst_no,
   output logic                      done_o
);

`ifdef BOOT_LOADER_FAST_READ_EN
   localparam logic [7:0] ReadOpcode = 8'h0B;
`else
   localparam logic [7:0] ReadOpcode = 8'h03;
`endif

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [RAM_ADDR_WIDTH-1:0] LastWord = RAM_ADDR_WIDTH'(BOOT_WORDS - 1);

`ifdef BOOT_LOADER_FAST_READ_EN
   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StDummy, StData, StDone
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StData, StDone
   } state_e;
`endif

   state_e                    state_q, state_d;
   logic [DivW-1:0]           div_q, div_d;
   logic                      sck_q, sck_d;
   logic                      cs_q, cs_d;
   logic [31:0]               tx_q, tx_d;      // opcode+address, MSB drives sdo_o
   logic [31:0]               rx_q, rx_d;      // incoming bits, first bit ends up at [31]
   logic [4:0]                bit_q, bit_d;    // SCK cycles completed in the current phase
   logic [RAM_ADDR_WIDTH-1:0] word_q, word_d;
   logic                      wr_q, wr_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic                      last_q, last_d;  // final word has been captured
   logic                      done_q, done_d;

   logic active;
   logic tick;
   logic rise;
   logic fall;

   // ------------------------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         div_q   <= '0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      word_d  = word_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      done_d  = done_q;
      tick    = 1'b0;

      active = (state_q != StIdle) && (state_q != StDone);

      // SCK phase timer: free-running while the flash is selected so bits are back to back
      if (active) begin
         if (div_q == DivLast) begin
            div_d = '0;
            tick  = 1'b1;
         end else begin
            div_d = div_q + DivW'(1);
         end
      end

      rise = tick & ~sck_q;
      fall = tick & sck_q;

      if (tick) begin
         sck_d = ~sck_q;
      end

      // Mode 0: the next outgoing bit is presented together with the falling edge
      if (fall) begin
         tx_d  = {tx_q[30:0], 1'b0};
         bit_d = bit_q + 5'd1;
      end

      unique case (state_q)
         StIdle: begin
            state_d = StCmd;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            tx_d    = {ReadOpcode, FLASH_OFFSET};
         end

         StCmd: begin
            if (fall && (bit_q == 5'd7)) begin
               state_d = StAddr;
               bit_d   = '0;
            end
         end

         StAddr: begin
            if (fall && (bit_q == 5'd23)) begin
`ifdef BOOT_LOADER_FAST_READ_EN
               state_d = StDummy;
`else
               state_d = StData;
`endif
               bit_d   = '0;
            end
         end

`ifdef BOOT_LOADER_FAST_READ_EN
         StDummy: begin
            // tx_q is already all zeros here, so sdo_o stays low; sdi_i is not sampled
            if (fall && (bit_q == 5'd7)) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
`endif

         StData: begin
            // bit_q wraps 31 -> 0 on its own at each word boundary
            if (rise) begin
               rx_d = {rx_q[30:0], sdi_i};
               if (bit_q == 5'd31) begin
                  wr_d    = 1'b1;
                  addr_d  = word_q;
                  // first received byte sits in rx_d[31:24] and belongs in wdata[7:0]
                  wdata_d = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
                  if (word_q == LastWord) begin
                     last_d = 1'b1;
                  end else begin
                     word_d = word_q + RAM_ADDR_WIDTH'(1);
                  end
               end
            end
            // Leave on the falling edge that closes the last bit so SCK ends low
            if (fall && (bit_q == 5'd31) && last_q) begin
               state_d = StDone;
               cs_d    = 1'b1;
               done_d  = 1'b1;
            end
         end

         StDone: begin
            state_d = StDone;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign sck_o       = sck_q;
   assign sdo_o       = tx_q[31];
   assign cs_o        = cs_q;
   assign done_o      = done_q;
   assign core_rst_no = done_q;

   // RAM port 0 belongs to the loader until DONE, then to the SoC with no added latency
   always_comb begin
      if (done_q) begin
         ram_en_o    = soc_en_i;
         ram_we_o    = soc_we_i;
         ram_be_o    = soc_be_i;
         ram_addr_o  = soc_addr_i;
         ram_wdata_o = soc_wdata_i;
      end else begin
         ram_en_o    = wr_q;
         ram_we_o    = wr_q;
         ram_be_o    = {4{wr_q}};
         ram_addr_o  = addr_q;
         ram_wdata_o = wdata_q;
      end
   end

endmodule

// File: doc/ram_boot_loader.md
RAM_BOOT_LOADER -- requirements
Module: ram_boot_loader

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 11, meaning the RAM word-address width.
REQ-002 SHALL have parameter BOOT_WORDS, default 2048, meaning the number of 32-bit words copied from flash; legal range 1..2**RAM_ADDR_WIDTH.
REQ-003 SHALL have parameter FLASH_OFFSET, default 24'h100000, meaning the flash byte address of the first image byte.
REQ-004 SHALL have parameter CLK_DIV, default 2, meaning the SCK half-period in clk_i cycles; minimum 1.
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and rst_ni (in, 1, asynchronous active-low reset).
REQ-006 SHALL have SPI ports sck_o (out, 1, serial clock), sdo_o (out, 1, data to flash), sdi_i (in, 1, data from flash) and cs_o (out, 1, active-low chip select).
REQ-007 SHALL have SoC-side request ports soc_en_i (in, 1), soc_we_i (in, 1), soc_be_i (in, 4), soc_addr_i (in, RAM_ADDR_WIDTH) and soc_wdata_i (in, 32).
REQ-008 SHALL have RAM-side ports ram_en_o (out, 1), ram_we_o (out, 1), ram_be_o (out, 4), ram_addr_o (out, RAM_ADDR_WIDTH) and ram_wdata_o (out, 32), which drive the SRAM wrapper port 0.
REQ-009 SHALL have status ports core_rst_no (out, 1, active-low reset to the CPU core) and done_o (out, 1, high when the image is loaded).

Function
REQ-010 SHALL implement the FSM states IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> DONE, with IDLE advancing to CMD one cycle after reset is released.
REQ-011 SHALL, in CMD, shift 8 bits of the read opcode, MSB first.
REQ-012 SHALL, in ADDR, shift the 24 bits of FLASH_OFFSET, MSB first.
REQ-013 SHALL, in DATA, shift in BOOT_WORDS*32 bits as one continuous read, with cs_o held low from the first CMD bit to the last DATA bit.
REQ-014 SHALL use SPI mode 0: sck_o idles low, sdo_o changes after the SCK falling edge, and sdi_i is sampled on the SCK rising edge.
REQ-015 SHALL hold each SCK level for exactly CLK_DIV clk_i cycles, with no gaps between bits or words.
REQ-016 SHALL assemble each word little-endian by byte: the first received byte goes to wdata[7:0] and the fourth to wdata[31:24], with each byte MSB first.
REQ-017 SHALL, in the clk_i cycle after the 32nd bit of word k is sampled, assert ram_en_o=1, ram_we_o=1, ram_be_o=4'hF, ram_addr_o=k and ram_wdata_o=the word, for exactly one cycle.
REQ-018 SHALL increment the word counter k from 0 and move to DONE once word BOOT_WORDS-1 has been written; k never wraps.
REQ-019 SHALL, in DONE, drive cs_o=1, sck_o=0, done_o=1 and core_rst_no=1, both registered and asserted in the same cycle.
REQ-020 SHALL, in DONE, pass the ram_* outputs combinationally from the soc_* inputs.
REQ-021 SHALL, before DONE, ignore the soc_* inputs and force ram_en_o=0 except during the write pulses of REQ-017.
REQ-022 SHALL hold core_rst_no=0 in every state before DONE.
REQ-023 SHALL keep DONE until the next reset.
REQ-024 SHALL take total load time (8+24+D+32*BOOT_WORDS)*2*CLK_DIV +/- 3 cycles, where D = 8 with FAST_READ and 0 without.

Reset
REQ-025 SHALL, on asserting rst_ni, immediately set the state to IDLE, cs_o=1, sck_o=0, sdo_o=0, ram_en_o=0, ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_wdata_o=0, done_o=0, core_rst_no=0 and clear all counters.
REQ-026 SHALL treat a reset during any state, DONE included, as aborting the transfer; a new load starts from word 0 after release.

Configuration
REQ-027 SHALL compile in the FAST_READ feature when macro BOOT_LOADER_FAST_READ_EN is defined: opcode 8'h0B, plus the DUMMY state of 8 SCK cycles with sdo_o=0 and sdi_i ignored.
REQ-028 SHALL, without BOOT_LOADER_FAST_READ_EN, use opcode 8'h03, with no DUMMY state in the hardware and ADDR moving directly to DATA.

Verification
REQ-029 SHALL cover a basic load: BOOT_WORDS=4, CLK_DIV=1, flash model bytes 00..0F at FLASH_OFFSET -> writes addr 0..3 with data 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C; then done_o=1 and core_rst_no=1.
REQ-030 SHALL cover the command and address bits: with no macro defined, the first 32 sdo_o bits equal 8'h03 followed by 24'h100000; with BOOT_LOADER_FAST_READ_EN defined they equal 8'h0B and 24'h100000, followed by 8 dummy SCK cycles before the first sampled data bit.
REQ-031 SHALL cover timing: CLK_DIV=3, BOOT_WORDS=2 -> every SCK high and low phase is 3 cycles, and done_o rises at (8+24+64)*6 +/- 3 cycles after reset release with no macro defined.
REQ-032 SHALL cover arbitration: soc_en_i=1, soc_we_i=1, soc_addr_i=5 toggled throughout the load -> no ram_en_o except the loader's write pulses; after done_o, ram_* mirror soc_* in the same cycle.
REQ-033 SHALL cover a mid-load reset: assert rst_ni low during word 2 of 4 -> cs_o goes high asynchronously and core_rst_no stays 0; after release the load restarts with a write to addr 0.
REQ-034 SHALL cover boundary sizes: BOOT_WORDS=1 -> exactly one ram write, at addr 0; BOOT_WORDS=2**RAM_ADDR_WIDTH -> the last write is at addr 2**RAM_ADDR_WIDTH-1 with no wrap-around write to addr 0.
